operand_skew_feeder: RTL and testbench

- Sits directly downstream of micro_controller and consumes its address/control stream.
- Issues reads to the activation RAM (synchronous read, 1-cycle latency).
- Forms one operand per array row from RAM data under control of the input pattern.
- Applies diagonal skew (row k delayed k cycles) and aligns clear-accumulate and pass-data-left controls to the skewed data entering the systolic array.

---
 rtl/operand_skew_feeder_if.sv | 40 ++++
 rtl/operand_skew_feeder.sv | 132 +++++++++++++
 tb/tb_operand_skew_feeder.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_skew_feeder_if.sv
// Bundles the request stream from micro_controller, the activation RAM
// read port and the skewed operand/control outputs toward the systolic array.
interface operand_skew_feeder_if #(
    parameter int unsigned ARRAY_NUM = 3,
    parameter int unsigned RAM_DEPTH = 2048
);
    localparam int unsigned AW = $clog2(RAM_DEPTH);

    // Request stream from micro_controller
    logic                     iAddrValid;
    logic [AW-1:0]            iAddr;
    logic [8*ARRAY_NUM+7:0]   iInputPattern;
    logic [ARRAY_NUM-2:0]     iPassDataLeft;
    logic                     iClearAcc;

    // Activation RAM read port
    logic                     oRamRdEn;
    logic [AW-1:0]            oRamAddr;
    logic [8*ARRAY_NUM-1:0]   iRamRdData;

    // Skewed stream into the array
    logic [8*ARRAY_NUM-1:0]   oLaneData;
    logic [ARRAY_NUM-1:0]     oLaneValid;
    logic                     oClearAcc;
    logic [ARRAY_NUM-2:0]     oPassDataLeft;
    logic                     oBusy;
    logic                     oDrainDone;

    modport master (
        output iAddrValid, iAddr, iInputPattern, iPassDataLeft, iClearAcc, iRamRdData,
        input  oRamRdEn, oRamAddr, oLaneData, oLaneValid, oClearAcc, oPassDataLeft,
               oBusy, oDrainDone
    );

    modport slave (
        input  iAddrValid, iAddr, iInputPattern, iPassDataLeft, iClearAcc, iRamRdData,
        output oRamRdEn, oRamAddr, oLaneData, oLaneValid, oClearAcc, oPassDataLeft,
               oBusy, oDrainDone
    );
endinterface

// File: rtl/operand_skew_feeder.sv
// Turns the micro_controller address stream into per-row operands for the
// systolic array: issues RAM reads, selects each lane's byte by pattern code,
// then skews lane k by k cycles with clear/pass controls kept aligned.
module operand_skew_feeder #(
    parameter int unsigned ARRAY_NUM = 3,
    parameter int unsigned RAM_DEPTH = 2048
) (
    input logic                 iClk,
    input logic                 iRst,
    operand_skew_feeder_if.slave bus
);
    localparam int unsigned AW = $clog2(RAM_DEPTH);
    localparam int unsigned PW = 8 * ARRAY_NUM + 8;

    logic [AW-1:0]        rd_addr;
    logic                 s1_valid_q;
    logic [PW-1:0]        s1_pat_q;
    logic [ARRAY_NUM-2:0] s1_pass_q;
    logic                 s1_clr_q;
    logic                 s2_clr_q;
    logic [7:0]           cbyte;
    logic [7:0]           opnd_d [ARRAY_NUM];
    logic [7:0]           hold_q [ARRAY_NUM];
    logic [ARRAY_NUM-1:0] lane_busy;
    logic                 busy;
    logic                 busy_q;

    // Reads are issued straight from the request; there is no backpressure.
    assign rd_addr      = bus.iAddr;
    assign bus.oRamAddr = rd_addr;
    assign bus.oRamRdEn = bus.iAddrValid;

    // S1: capture request controls alongside the RAM's one-cycle read latency.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            s1_valid_q <= 1'b0;
            s1_pat_q   <= '0;
            s1_pass_q  <= '0;
            s1_clr_q   <= 1'b0;
        end else begin
            s1_valid_q <= bus.iAddrValid;
            s1_pat_q   <= bus.iInputPattern;
            s1_pass_q  <= bus.iPassDataLeft;
            s1_clr_q   <= bus.iClearAcc;
        end
    end

    assign cbyte = s1_pat_q[8*ARRAY_NUM +: 8];

    // Operand select per lane from its pattern code; unknown codes give zero.
    always_comb begin
        for (int k = 0; k < ARRAY_NUM; k++) begin
            opnd_d[k] = 8'h00;
            case (s1_pat_q[8*k +: 8])
                8'h01:   opnd_d[k] = bus.iRamRdData[8*k +: 8];
                8'h02:   opnd_d[k] = hold_q[k];
                8'h03:   opnd_d[k] = cbyte;
                default: opnd_d[k] = 8'h00;
            endcase
        end
    end

    // Hold registers remember the last operand formed on a valid stage.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int k = 0; k < ARRAY_NUM; k++) hold_q[k] <= 8'h00;
        end else if (s1_valid_q) begin
            for (int k = 0; k < ARRAY_NUM; k++) hold_q[k] <= opnd_d[k];
        end
    end

    // Clear travels with lane 0, so it only needs the S2 register.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) s2_clr_q <= 1'b0;
        else      s2_clr_q <= s1_valid_q & s1_clr_q;
    end

    assign bus.oClearAcc = s2_clr_q;

    for (genvar k = 0; k < ARRAY_NUM; k++) begin : g_lane
        // Stage 0 is S2; stages 1..k form the diagonal skew for this lane.
        logic [k:0] v_q;
        logic [7:0] d_q [k+1];

        // Shift operand and valid down this lane's skew chain.
        always_ff @(posedge iClk or posedge iRst) begin
            if (iRst) begin
                v_q <= '0;
                for (int s = 0; s <= k; s++) d_q[s] <= 8'h00;
            end else begin
                v_q[0] <= s1_valid_q;
                d_q[0] <= s1_valid_q ? opnd_d[k] : 8'h00;
                for (int s = 1; s <= k; s++) begin
                    v_q[s] <= v_q[s-1];
                    d_q[s] <= d_q[s-1];
                end
            end
        end

        assign bus.oLaneValid[k]       = v_q[k];
        assign bus.oLaneData[8*k +: 8] = v_q[k] ? d_q[k] : 8'h00;
        assign lane_busy[k]            = |v_q;

        if (k > 0) begin : g_pass
            // Boundary k-1 pass control rides alongside lane k's data.
            logic [k:0] p_q;

            // Delay the pass bit by the same skew as lane k.
            always_ff @(posedge iClk or posedge iRst) begin
                if (iRst) begin
                    p_q <= '0;
                end else begin
                    p_q[0] <= s1_valid_q & s1_pass_q[k-1];
                    for (int s = 1; s <= k; s++) p_q[s] <= p_q[s-1];
                end
            end

            assign bus.oPassDataLeft[k-1] = p_q[k] & v_q[k];
        end
    end

    assign busy       = s1_valid_q | (|lane_busy);
    assign bus.oBusy  = busy;

    // Remember last cycle's busy so the falling edge can be flagged.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) busy_q <= 1'b0;
        else      busy_q <= busy;
    end

    assign bus.oDrainDone = busy_q & ~busy;
endmodule

// File: tb/tb_operand_skew_feeder.sv
// Directed bench for operand_skew_feeder with ARRAY_NUM=3: a synchronous RAM
// model feeds read data back one cycle after each read enable.
module tb_operand_skew_feeder;
    localparam int unsigned N     = 3;
    localparam int unsigned DEPTH = 2048;
    localparam int unsigned AW    = 11;
    localparam logic [31:0] PAT_RAM = 32'h00010101;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    logic [23:0] mem [DEPTH];
    logic [31:0] obs;

    always #5 clk = ~clk;

    operand_skew_feeder_if #(.ARRAY_NUM(N), .RAM_DEPTH(DEPTH)) bus ();

    operand_skew_feeder #(.ARRAY_NUM(N), .RAM_DEPTH(DEPTH)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus.slave)
    );

    // Synchronous-read RAM model, one cycle of latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus.iRamRdData <= '0;
        else if (bus.oRamRdEn) bus.iRamRdData <= mem[bus.oRamAddr];
    end

    // [31:29] valid, [28:5] data, [4] clear, [3:2] pass, [1] busy, [0] drain
    assign obs = {bus.oLaneValid, bus.oLaneData, bus.oClearAcc, bus.oPassDataLeft,
                  bus.oBusy, bus.oDrainDone};

    task automatic drive(input logic v, input logic [AW-1:0] a, input logic [31:0] p,
                         input logic [1:0] pl, input logic c);
        bus.iAddrValid    = v;
        bus.iAddr         = a;
        bus.iInputPattern = p;
        bus.iPassDataLeft = pl;
        bus.iClearAcc     = c;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 2'b00, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1;
        #3;
        vectors++;
        if ({obs, bus.oRamRdEn} !== 33'h0)
            $display("FAIL reset_hold got %h want %h", {obs, bus.oRamRdEn}, 33'h0);
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (obs !== 32'h0) $display("FAIL reset_release got %h want %h", obs, 32'h0);
        if (obs !== 32'h0) miscompares++;
        if ({obs, bus.oRamRdEn} !== 33'h0 && vectors == 1) miscompares++;
    endtask

    task automatic test_single();
        logic [31:0] exp;
        drive(1'b1, 11'd5, PAT_RAM, 2'b00, 1'b0);
        #1;
        vectors++;
        if ({bus.oRamRdEn, bus.oRamAddr} !== {1'b1, 11'd5}) begin
            miscompares++;
            $display("FAIL single_rd_issue got %h want %h", {bus.oRamRdEn, bus.oRamAddr},
                     {1'b1, 11'd5});
        end
        for (int c = 1; c <= 6; c++) begin
            tick();
            idle();
            exp = '0;
            if (c >= 2 && c <= 4) begin
                exp[29+(c-2)]         = 1'b1;
                exp[5+8*(c-2) +: 8]   = 8'(c - 1);
            end
            exp[1] = (c <= 4);
            exp[0] = (c == 5);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL single c=%0d got %h want %h", c, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int r;
        for (int n = 0; n <= 8; n++) begin
            if (n <= 3) drive(1'b1, 11'(n), PAT_RAM, 2'b00, 1'b0);
            else        idle();
            tick();
            exp = '0;
            for (int k = 0; k < 3; k++) begin
                r = n + 1 - 2 - k;
                if (r >= 0 && r <= 3) begin
                    exp[29+k]        = 1'b1;
                    exp[5+8*k +: 8]  = 8'(r * 16 + k);
                end
            end
            exp[1] = (n + 1 <= 7);
            exp[0] = (n + 1 == 8);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL back_to_back c=%0d got %h want %h", n + 1, obs, exp);
            end
        end
    endtask

    task automatic test_pattern();
        logic [31:0] exp;
        logic [31:0] pats [4];
        logic [23:0] pd [4];
        int r;
        pats = '{32'h55030000, 32'h7E020300, 32'hAA090909, 32'h00020201};
        pd   = '{24'h550000, 24'h557E00, 24'h000000, 24'h0000FF};
        for (int n = 0; n <= 8; n++) begin
            if (n <= 3) drive(1'b1, 11'd7, pats[n], 2'b00, 1'b0);
            else        idle();
            tick();
            exp = '0;
            for (int k = 0; k < 3; k++) begin
                r = n + 1 - 2 - k;
                if (r >= 0 && r <= 3) begin
                    exp[29+k]       = 1'b1;
                    exp[5+8*k +: 8] = pd[r][8*k +: 8];
                end
            end
            exp[1] = (n + 1 <= 7);
            exp[0] = (n + 1 == 8);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL pattern c=%0d got %h want %h", n + 1, obs, exp);
            end
        end
    endtask

    task automatic test_controls();
        logic [31:0] exp;
        int r;
        for (int n = 0; n <= 7; n++) begin
            if (n == 0)      drive(1'b1, 11'd5, PAT_RAM, 2'b10, 1'b1);
            else if (n == 2) drive(1'b1, 11'd5, PAT_RAM, 2'b01, 1'b0);
            else             idle();
            tick();
            exp = '0;
            for (int k = 0; k < 3; k++) begin
                r = n + 1 - 2 - k;
                if (r == 0 || r == 2) begin
                    exp[29+k]       = 1'b1;
                    exp[5+8*k +: 8] = 8'(k + 1);
                end
            end
            exp[4] = (n + 1 == 2);
            exp[3] = (n + 1 == 4);
            exp[2] = (n + 1 == 5);
            exp[1] = (n + 1 <= 6);
            exp[0] = (n + 1 == 7);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL controls c=%0d got %h want %h", n + 1, obs, exp);
            end
        end
    endtask

    task automatic test_gap();
        logic [31:0] exp;
        int r;
        for (int n = 0; n <= 7; n++) begin
            if (n == 0)      drive(1'b1, 11'd1, PAT_RAM, 2'b00, 1'b0);
            else if (n == 2) drive(1'b1, 11'd2, PAT_RAM, 2'b00, 1'b0);
            else             idle();
            tick();
            exp = '0;
            for (int k = 0; k < 3; k++) begin
                r = n + 1 - 2 - k;
                if (r == 0 || r == 2) begin
                    exp[29+k]       = 1'b1;
                    exp[5+8*k +: 8] = 8'((r == 0 ? 16 : 32) + k);
                end
            end
            exp[1] = (n + 1 <= 6);
            exp[0] = (n + 1 == 7);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL gap c=%0d got %h want %h", n + 1, obs, exp);
            end
        end
    endtask

    task automatic test_reset_midstream();
        logic [31:0] exp;
        for (int n = 0; n <= 2; n++) begin
            drive(1'b1, 11'(n), PAT_RAM, 2'b11, 1'b1);
            tick();
        end
        idle();
        vectors++;
        if (bus.oBusy !== 1'b1) begin
            miscompares++;
            $display("FAIL midstream_busy got %b want %b", bus.oBusy, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== 32'h0) begin
            miscompares++;
            $display("FAIL midstream_async got %h want %h", obs, 32'h0);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            vectors++;
            if (obs !== 32'h0) begin
                miscompares++;
                $display("FAIL midstream_no_drain c=%0d got %h want %h", c, obs, 32'h0);
            end
        end
        drive(1'b1, 11'd5, PAT_RAM, 2'b00, 1'b0);
        for (int c = 1; c <= 6; c++) begin
            tick();
            idle();
            exp = '0;
            if (c >= 2 && c <= 4) begin
                exp[29+(c-2)]       = 1'b1;
                exp[5+8*(c-2) +: 8] = 8'(c - 1);
            end
            exp[1] = (c <= 4);
            exp[0] = (c == 5);
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL after_reset c=%0d got %h want %h", c, obs, exp);
            end
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = {8'(a * 16 + 2), 8'(a * 16 + 1), 8'(a * 16)};
        mem[5] = 24'h030201;
        mem[7] = 24'hFFFFFF;
        idle();
        test_reset();
        test_single();
        test_back_to_back();
        test_pattern();
        test_controls();
        test_gap();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
